// File: rtl/ann_bram_pkg.sv
// Shared defaults, burst FSM state type and address-width helper for the
// ANN weight memories.
package ann_bram_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANES  = 1;
  localparam int DEF_DEPTH  = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } bram_state_t;

  // Smallest address width that covers depth words (at least 1 bit).
  function automatic int addr_w_for(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry valid/ready buffer with a LAST sideband; head drives the stream.
module weight_skid_fifo #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_data [2];
  logic [1:0]   r_lastq;
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data[r_rd_ptr];
  assign o_last  = r_lastq[r_rd_ptr];
  assign o_count = r_count;

  assign w_pop  = o_valid & i_ready;
  // The upstream credit rule keeps pushes off a full buffer; the guard only
  // protects the contents if that rule is ever broken.
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  // Storage, pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) r_data[i] <= '0;
      r_lastq  <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr]  <= i_data;
        r_lastq[r_wr_ptr] <= i_last;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/weight_stream_bram.sv
// Parameterised weight BRAM with host write port and a burst read engine
// streaming LEN consecutive (wrapping) words over valid/ready.
module weight_stream_bram
  import ann_bram_pkg::*;
#(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    LANES     = DEF_LANES,
  parameter int    DEPTH     = DEF_DEPTH,
  parameter int    ADDR_W    = addr_w_for(DEF_DEPTH),
  parameter int    LEN_W     = 6,
  parameter string INIT_FILE = "weight.txt"
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_EN,
  input  logic [ADDR_W-1:0]       WR_ADDR,
  input  logic [LANES*DATA_W-1:0] WR_DATA,
  input  logic                    START,
  input  logic [ADDR_W-1:0]       BASE,
  input  logic [LEN_W-1:0]        LEN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR,
  output logic [LANES*DATA_W-1:0] DO,
  output logic                    DO_VALID,
  input  logic                    DO_READY,
  output logic                    DO_LAST
);

  localparam int                WORD_W  = LANES * DATA_W;
  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

  (* ram_style = "block" *) logic [WORD_W-1:0] r_mem [DEPTH];

  bram_state_t       r_state;
  bram_state_t       w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic              r_rd_vld;
  logic              r_rd_last;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_done;
  logic              r_err;

  logic              w_base_ok;
  logic              w_start_go;
  logic              w_start_err;
  logic              w_start_zero;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_accept;
  logic              w_last_acc;
  logic [1:0]        w_fifo_cnt;
  logic [2:0]        w_credit;

  assign w_base_ok    = ({1'b0, BASE} < LP_DEPTH);
  assign w_start_go   = (r_state == ST_IDLE) & START & w_base_ok & (LEN != '0);
  assign w_start_err  = (r_state == ST_IDLE) & START & ~w_base_ok;
  assign w_start_zero = (r_state == ST_IDLE) & START & w_base_ok & (LEN == '0);

  assign w_accept   = DO_VALID & DO_READY;
  assign w_last_acc = w_accept & DO_LAST;
  // Slots committed after this edge: occupancy, minus the word leaving now,
  // plus the read already in flight. Counting the pop keeps 1 word/cycle.
  assign w_credit = {1'b0, w_fifo_cnt} - {2'b0, w_accept} + {2'b0, r_rd_vld};

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_go) w_next = ST_READ;
      ST_READ:  if (w_issue && w_issue_last) w_next = ST_DRAIN;
      ST_DRAIN: if (w_last_acc) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and read-issue gating.
  always_comb begin
    BUSY         = (r_state != ST_IDLE);
    w_issue      = (r_state == ST_READ) && (w_credit < 3'd2);
    w_issue_last = (r_remain == LEN_W'(1));
  end

  // Burst address/length counters and read-pipeline valid/last tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr    <= '0;
      r_remain  <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      if (w_start_go) begin
        r_addr   <= BASE;
        r_remain <= LEN;
      end else if (w_issue) begin
        r_addr   <= (r_addr == LP_LAST) ? '0 : r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue & w_issue_last;
    end
  end

  // One-cycle status pulses; a reset mid-burst suppresses DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_start_zero | ((r_state == ST_DRAIN) & w_last_acc);
      r_err  <= w_start_err;
    end
  end

  assign DONE = r_done;
  assign ERR  = r_err;

  // Block RAM: read-first, unreset so contents survive RST; writes past the
  // end of the array are dropped.
  always_ff @(posedge CLK) begin
    if (WR_EN && ({1'b0, WR_ADDR} < LP_DEPTH)) r_mem[WR_ADDR] <= WR_DATA;
    if (w_issue) r_rd_data <= r_mem[r_addr];
  end

  weight_skid_fifo #(.W(WORD_W)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (r_rd_vld),
    .i_data  (r_rd_data),
    .i_last  (r_rd_last),
    .i_ready (DO_READY),
    .o_valid (DO_VALID),
    .o_data  (DO),
    .o_last  (DO_LAST),
    .o_count (w_fifo_cnt)
  );

endmodule

// File: tb/tb_weight_stream_bram.sv
// Directed bench for weight_stream_bram: host preload, bursts with wrap,
// backpressure, error/zero-length starts, mid-burst write and reset abort.
module tb_weight_stream_bram;

  localparam int DW = 16;
  localparam int DP = 28;
  localparam int AW = 5;
  localparam int LW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          START;
  logic [AW-1:0] BASE;
  logic [LW-1:0] LEN;
  logic          BUSY, DONE, ERR;
  logic [DW-1:0] DO;
  logic          DO_VALID, DO_READY, DO_LAST;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] mem_m [DP];

  always #5 CLK = ~CLK;

  weight_stream_bram #(
    .DATA_W(DW), .LANES(1), .DEPTH(DP), .ADDR_W(AW), .LEN_W(LW), .INIT_FILE("")
  ) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START), .BASE(BASE), .LEN(LEN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .DO(DO), .DO_VALID(DO_VALID), .DO_READY(DO_READY), .DO_LAST(DO_LAST)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // rmode 0: ready always high; 1: ready follows 1,0,0,1,0,1 repeating.
  // wr_c >= 0: write ABCD to address 10 on the edge after loop cycle wr_c.
  // rst_after > 0: assert RST once that many words have been accepted.
  // poke: issue an out-of-range START while the burst is busy.
  task automatic burst(input string tag, input logic [AW-1:0] base, input logic [LW-1:0] len,
                       input int rmode, input int wr_c, input int rst_after, input bit poke);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    bit   [5:0]    pat = 6'b101001;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    bit            stall, fin, rdy;
    int            c, nacc, first_c, done_pre, err_seen;
    for (int i = 0; i < int'(len); i++) expq.push_back(mem_m[(int'(base) + i) % DP]);
    BASE = base; LEN = len; START = 1'b1;
    step;
    START = 1'b0;
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    c = 0; nacc = 0; first_c = -1; done_pre = 0; err_seen = 0;
    stall = 1'b0; fin = 1'b0; prev_d = '0; prev_l = 1'b0;
    while (!fin && c < 100) begin
      if (DO_VALID && first_c < 0) first_c = c;
      if (DONE) done_pre++;
      if (ERR) err_seen++;
      if (stall) chk({tag, "_hold"}, 32'({DO_LAST, DO}), 32'({prev_l, prev_d}));
      rdy = (rmode == 0) ? 1'b1 : pat[c % 6];
      DO_READY = rdy;
      if (poke && c == 1) begin START = 1'b1; BASE = 5'd28; LEN = 6'd1; end
      else START = 1'b0;
      WR_EN = (c == wr_c); WR_ADDR = 5'd10; WR_DATA = 16'hABCD;
      stall = DO_VALID && !rdy; prev_d = DO; prev_l = DO_LAST;
      if (DO_VALID && rdy) begin
        got_d.push_back(DO); got_l.push_back(DO_LAST); nacc++;
        if (DO_LAST) fin = 1'b1;
      end
      step;
      c++;
      if (rst_after > 0 && nacc == rst_after && !fin) begin
        RST = 1'b1; DO_READY = 1'b0; WR_EN = 1'b0; START = 1'b0;
        step;
        chk({tag, "_rst_valid"}, 32'(DO_VALID), 32'd0);
        chk({tag, "_rst_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_rst_done"}, 32'(DONE), 32'd0);
        RST = 1'b0;
        step;
        chk({tag, "_rst_done2"}, 32'(DONE), 32'd0);
        return;
      end
    end
    WR_EN = 1'b0; START = 1'b0;
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_done"}, 32'(DONE), 32'd1);
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
    chk({tag, "_done_early"}, 32'(done_pre), 32'd0);
    chk({tag, "_err"}, 32'(err_seen), 32'd0);
    chk({tag, "_first"}, 32'(first_c), 32'd2);
    chk({tag, "_count"}, 32'(got_d.size()), 32'(len));
    for (int i = 0; i < got_d.size() && i < expq.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), 32'(got_d[i]), 32'(expq[i]));
      chk($sformatf("%s_l%0d", tag, i), 32'(got_l[i]), 32'(i == int'(len) - 1));
    end
    DO_READY = 1'b0;
    step;
    chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    chk({tag, "_idle_valid"}, 32'(DO_VALID), 32'd0);
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    START = 1'b0; BASE = '0; LEN = '0; DO_READY = 1'b0;
    step; step;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_valid", 32'(DO_VALID), 32'd0);
    chk("rst_last", 32'(DO_LAST), 32'd0);
    chk("rst_do", 32'(DO), 32'd0);
    RST = 1'b0;
    step;

    // Host preload: word i = i.
    for (int i = 0; i < DP; i++) begin
      WR_EN = 1'b1; WR_ADDR = AW'(i); WR_DATA = DW'(i); mem_m[i] = DW'(i);
      step;
    end
    WR_EN = 1'b0;
    step;

    burst("b3", 5'd3, 6'd4, 0, -1, 0, 1'b0);   // 3,4,5,6
    burst("wrap", 5'd26, 6'd4, 0, -1, 0, 1'b1); // 26,27,0,1 + ignored START
    burst("stall", 5'd0, 6'd5, 1, -1, 0, 1'b0); // 0..4 under backpressure

    // Out-of-range base.
    BASE = 5'd28; LEN = 6'd4; START = 1'b1;
    step;
    START = 1'b0;
    chk("err_pulse", 32'(ERR), 32'd1);
    chk("err_busy", 32'(BUSY), 32'd0);
    step;
    chk("err_clear", 32'(ERR), 32'd0);
    chk("err_valid", 32'(DO_VALID), 32'd0);

    // Zero-length burst.
    BASE = 5'd3; LEN = 6'd0; START = 1'b1;
    step;
    START = 1'b0;
    chk("len0_done", 32'(DONE), 32'd1);
    chk("len0_busy", 32'(BUSY), 32'd0);
    chk("len0_valid", 32'(DO_VALID), 32'd0);
    step;
    chk("len0_done_clear", 32'(DONE), 32'd0);
    chk("len0_valid2", 32'(DO_VALID), 32'd0);

    // Write to address 10 on the same edge its read issues: old data streams.
    burst("midwr", 5'd8, 6'd6, 0, 2, 0, 1'b0);
    mem_m[10] = 16'hABCD;

    burst("rst", 5'd0, 6'd8, 0, -1, 2, 1'b0);
    burst("after", 5'd8, 6'd4, 0, -1, 0, 1'b0); // 8,9,ABCD,11

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
